// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back source indices.
package regfile_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_CSR = 2;

    // (a + b) mod n for operands already below n; avoids a real divider.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back request bundle: N requesters, each with valid/addr/data and a grant back.
interface regfile_wb_scheduler_if
    import regfile_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::REG_AW
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ*XLEN-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant, pointer advances past each winner.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so the loop reads its own earlier result and no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        if (!reset) begin
            for (int off = 0; off < N; off++) begin
                w_cand = PW'(wrap_add(int'(r_ptr), off, N));
                if (!o_any && i_req[w_cand]) begin
                    o_any = 1'b1;
                    o_idx = w_cand;
                end
            end
        end
        if (o_any) o_grant[o_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)      r_ptr <= '0;
        else if (o_any) r_ptr <= PW'(wrap_add(int'(o_idx), 1, N));
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among write-back sources and tracks
// outstanding writes so decode can detect read-after-write hazards.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter  int N_REQ = 3,
    parameter  int XLEN  = regfile_pkg::XLEN,
    parameter  int AW    = regfile_pkg::REG_AW,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_scheduler_if.slave req_if,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_a3,
    output logic [XLEN-1:0]      rf_wd3,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        chk_a1,
    input  logic [AW-1:0]        chk_a2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic [2**AW-1:0]     pending
);
    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_idx;
    logic             w_any;
    logic [AW-1:0]    w_addr;
    logic [XLEN-1:0]  w_data;

    logic             r_we;
    logic [AW-1:0]    r_a3;
    logic [XLEN-1:0]  r_wd3;
    logic [2**AW-1:0] r_pending;
    logic [2**AW-1:0] w_pending_nxt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req_if.req_valid),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_if.req_ready = w_grant;
    assign w_addr = req_if.req_addr[w_idx*AW +: AW];
    assign w_data = req_if.req_data[w_idx*XLEN +: XLEN];

    // Address-0 writes finish their handshake but never enable the file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_any) begin
            r_we  <= (w_addr != '0);
            r_a3  <= w_addr;
            r_wd3 <= w_data;
        end else begin
            r_we  <= 1'b0;
        end
    end

    // Clear first, then set: a fresh producer outranks a retiring write.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_we) w_pending_nxt[r_a3] = 1'b0;
        if (iss_valid && (iss_rd != '0)) w_pending_nxt[iss_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it takes a full
    // reset; a restart must not inherit stale hazards.
    always_ff @(posedge clk) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_pending_nxt;
    end

    assign rf_we   = r_we;
    assign rf_a3   = r_a3;
    assign rf_wd3  = r_wd3;
    assign pending = r_pending;
    assign hazard1 = r_pending[chk_a1];
    assign hazard2 = r_pending[chk_a2];
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized checks of regfile_wb_scheduler against a behavioural model.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = REG_AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.N_REQ(N), .XLEN(XLEN), .AW(AW)) req_if ();

    logic            rf_we;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   chk_a1, chk_a2;
    logic            hazard1, hazard2;
    logic [31:0]     pending;

    regfile_wb_scheduler #(.N_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_if    (req_if),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .pending   (pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester stimulus state
    logic [N-1:0]    s_valid;
    logic [AW-1:0]   s_addr [N];
    logic [XLEN-1:0] s_data [N];

    // Behavioural model state
    int              m_ptr;
    logic [31:0]     m_pend;
    logic            m_we;
    logic [AW-1:0]   m_a3;
    logic [XLEN-1:0] m_wd3;
    int              last_g;

    task automatic apply();
        req_if.req_valid = s_valid;
        for (int i = 0; i < N; i++) begin
            req_if.req_addr[i*AW +: AW]     = s_addr[i];
            req_if.req_data[i*XLEN +: XLEN] = s_data[i];
        end
    endtask

    // One clock cycle: check all outputs against the model, then advance it.
    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        apply();
        #1;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && s_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("ready",   req_if.req_ready, exp_ready);
        check("rf_we",   rf_we,   m_we);
        check("rf_a3",   rf_a3,   m_a3);
        check("rf_wd3",  rf_wd3,  m_wd3);
        check("pending", pending, m_pend);
        check("hazard1", hazard1, m_pend[chk_a1]);
        check("hazard2", hazard2, m_pend[chk_a2]);
        last_g = g;
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_pend = '0;
        end else begin
            if (m_we) m_pend[m_a3] = 1'b0;
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (g >= 0) begin
                m_we  = (s_addr[g] != 0);
                m_a3  = s_addr[g];
                m_wd3 = s_data[g];
                m_ptr = (g + 1) % N;
            end else begin
                m_we = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rr_exp;
        int rd;

        reset = 1'b1; iss_valid = 1'b0; iss_rd = '0; chk_a1 = '0; chk_a2 = '0;
        s_valid = '0;
        for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_data[i] = '0; end
        apply();
        m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_pend = '0; last_g = -1;
        @(posedge clk);
        @(negedge clk);
        step();
        reset = 1'b0;

        // Single ALU write
        s_valid = 3'b001; s_addr[SRC_ALU] = 5'd5; s_data[SRC_ALU] = 32'hDEADBEEF;
        apply(); #1;
        check("alu_ready", req_if.req_ready, 3'b001);
        step();
        s_valid = '0;
        check("alu_we",  rf_we,  1'b1);
        check("alu_a3",  rf_a3,  5'd5);
        check("alu_wd3", rf_wd3, 32'hDEADBEEF);
        step();

        // Round-robin from a fresh pointer
        reset = 1'b1; step(); reset = 1'b0;
        s_valid = 3'b111;
        for (int i = 0; i < N; i++) begin s_addr[i] = AW'(10 + i); s_data[i] = $urandom; end
        for (int k = 0; k < 6; k++) begin
            apply(); #1;
            rr_exp = '0; rr_exp[k % 3] = 1'b1;
            check("rr_order", req_if.req_ready, rr_exp);
            step();
            if (k > 0) check("rr_we", rf_we, 1'b1);
            s_addr[k % 3] = AW'(13 + k); s_data[k % 3] = $urandom;
        end
        s_valid = '0;
        check("rr_we_last", rf_we, 1'b1);
        step();

        // Zero-register write from LSU
        s_valid = 3'b010; s_addr[SRC_LSU] = '0; s_data[SRC_LSU] = 32'h1;
        apply(); #1;
        check("zero_ready", req_if.req_ready, 3'b010);
        step();
        s_valid = '0;
        check("zero_we", rf_we, 1'b0);
        step();
        check("zero_pend", pending, 32'h0);

        // Scoreboard set and clear latency
        iss_valid = 1'b1; iss_rd = 5'd7; step(); iss_valid = 1'b0;
        chk_a1 = 5'd7; #1; check("sb_set", hazard1, 1'b1);
        chk_a1 = 5'd0; #1; check("sb_zero", hazard1, 1'b0);
        chk_a1 = 5'd7;
        s_valid = 3'b001; s_addr[SRC_ALU] = 5'd7; s_data[SRC_ALU] = $urandom;
        step();
        s_valid = '0; #1;
        check("sb_t1", hazard1, 1'b1);
        step(); #1;
        check("sb_t2", hazard1, 1'b0);

        // Set/clear collision on register 9
        s_valid = 3'b001; s_addr[SRC_ALU] = 5'd9; s_data[SRC_ALU] = $urandom;
        step();
        s_valid = '0; iss_valid = 1'b1; iss_rd = 5'd9;
        check("coll_we", rf_we, 1'b1);
        check("coll_a3", rf_a3, 5'd9);
        step();
        iss_valid = 1'b0; chk_a2 = 5'd9; #1;
        check("coll_pend9", pending[9], 1'b1);
        check("coll_haz2", hazard2, 1'b1);
        step();

        // Reset in the cycle after a grant
        iss_valid = 1'b1; iss_rd = 5'd12; step(); iss_valid = 1'b0;
        s_valid = 3'b010; s_addr[SRC_LSU] = 5'd3; s_data[SRC_LSU] = $urandom;
        step();
        s_valid = '0; reset = 1'b1;
        check("mid_we_before", rf_we, 1'b1);
        step();
        reset = 1'b0; s_valid = 3'b111;
        apply(); #1;
        check("mid_we",    rf_we,   1'b0);
        check("mid_pend",  pending, 32'h0);
        check("mid_ready", req_if.req_ready, 3'b001);
        step();
        if (last_g >= 0) s_valid[last_g] = 1'b0;

        // Randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
                    s_valid[i] = 1'b1;
                    s_addr[i]  = AW'($urandom_range(0, 31));
                    s_data[i]  = $urandom;
                end
            end
            rd = $urandom_range(0, 31);
            iss_rd    = AW'(rd);
            iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[rd];
            chk_a1 = AW'($urandom_range(0, 31));
            chk_a2 = AW'($urandom_range(0, 31));
            reset  = ($urandom_range(0, 63) == 0);
            step();
            if (last_g >= 0) s_valid[last_g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32 x 32-bit, single-write-port register file. It shares the one write port (a3/wd3/we) among N_REQ write-back sources with round-robin arbitration and a registered write stage. It also keeps a pending-write scoreboard so decode can detect read-after-write hazards on its two read addresses. It sits between the execution units (ALU, LSU, CSR) and the register file write port.

## Interface
- N_REQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clock clk
- req_valid  in  N_REQ  requester i holds a write
- req_ready  out  N_REQ  grant; one-hot or zero
- req_addr  in  N_REQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  N_REQ*XLEN  data of requester i, slice [i*XLEN +: XLEN]
- rf_we  out  1  register file write enable
- rf_a3  out  AW  register file write address
- rf_wd3  out  XLEN  register file write data
- iss_valid  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  AW  destination being issued
- chk_a1, chk_a2  in  AW  decode read addresses
- hazard1, hazard2  out  1  chk_aN has an outstanding write
- pending  out  2**AW  scoreboard bit vector

## Operation
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. req_ready is combinational from req_valid and the round-robin pointer. At most one bit is set per cycle, and only for a valid requester. A requester holds valid, addr and data stable until granted.
- Arbitration: search starts at rr_ptr and wraps modulo N_REQ. The first valid requester wins. After a grant to winner w, rr_ptr becomes (w+1) mod N_REQ. With no grant, rr_ptr holds.
- Write stage: on a grant, rf_a3 and rf_wd3 register the winner's addr and data. rf_we registers 1 if addr != 0, else 0. An address-0 write completes its handshake but never reaches the file.
- With no grant, rf_we is 0. rf_a3 and rf_wd3 hold their last values.
- Scoreboard set: iss_valid with iss_rd != 0 sets pending[iss_rd].
- Scoreboard clear: on the edge that ends a cycle with rf_we=1, pending[rf_a3] clears. This is the same edge at which the register file writes.
- Simultaneous set and clear of the same bit: set wins, because a new producer is outstanding.
- pending[0] is always 0.
- hazard1 = pending[chk_a1]; hazard2 = pending[chk_a2]. Both are combinational and 0 for address 0.
- Decode must not issue a write to a register that already has a pending write. This is not checked here.

## Timing
- Reset values:
  - rf_we=0, rf_a3=0, rf_wd3=0
  - rr_ptr=0, pending=0
  - req_ready=0 while reset is high
  - hazard1 and hazard2 are 0 after the first reset edge.
- Latency:
  - Grant in cycle T gives rf_we/rf_a3/rf_wd3 valid in cycle T+1.
  - The file is written at the end of T+1.
  - pending and hazard drop in T+2.
- Throughput: one write per cycle with no bubbles, sustained under continuous requests.
- Reset mid-operation: the in-flight registered write is dropped (rf_we=0 the next cycle), the scoreboard clears, and rr_ptr returns to 0.

## Structure
- Shared package regfile_pkg:
  - XLEN, REG_AW, NUM_REGS=2**REG_AW
  - source indices SRC_ALU=0, SRC_LSU=1, SRC_CSR=2
- Sub-module rr_arbiter holds the N-way round-robin grant logic and pointer register.
- The write-stage registers and the scoreboard stay in the top.

## Test plan
- Reset check: after reset, all outputs are 0; a single ALU request (addr=5, data=32'hDEADBEEF) gives ready[0]=1 in T and rf_we=1, rf_a3=5, rf_wd3=DEADBEEF in T+1.
- Round-robin: all three valid for 6 cycles from rr_ptr=0 give the grant order 0,1,2,0,1,2 and rf_we=1 in every cycle from T+1.
- Zero-register write: LSU request with addr=0 and data=1 gives ready[1]=1 and rf_we=0 in T+1; pending is unchanged.
- Scoreboard: issue rd=7 gives hazard1=1 for chk_a1=7 and hazard1=0 for chk_a1=0. A later grant with addr=7 clears hazard1 two cycles after the grant.
- Set/clear collision: rf_we=1 with rf_a3=9 in the same cycle as iss_valid with iss_rd=9 leaves pending[9]=1.
- Mid-operation reset: reset asserted during the cycle after a grant gives rf_we=0, pending=0 and the next grant from requester 0.
